// File: rtl/pcie_stream_pkg.sv
// Shared types and constants for the PCIe stream arbitration blocks.
package pcie_stream_pkg;

   // Arbiter FSM: waiting for a request, passing a packet, draining a cut packet.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PASS  = 2'd1,
      DRAIN = 2'd2
   } arb_state_t;

   localparam int DEFAULT_REQUESTERS  = 4;
   localparam int DEFAULT_DATA_WIDTH  = 64;
   localparam int DEFAULT_COUNT_WIDTH = 16;

   // Width of an index that can name any of n requesters (at least one bit).
   function automatic int owner_idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/round_robin_picker.sv
// Combinational round-robin selector: first request after i_last, wrapping.
module round_robin_picker
   import pcie_stream_pkg::*;
#(
   parameter int N  = DEFAULT_REQUESTERS,
   parameter int IW = owner_idx_width(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_last,
   output logic [N-1:0]  o_grant,
   output logic          o_found
);

   logic [IW-1:0] w_idx;

   // Walk the requesters starting one past the previous winner; the first hit wins.
   always_comb begin
      o_grant = '0;
      o_found = 1'b0;
      w_idx   = '0;
      for (int k = 1; k <= N; k++) begin
         w_idx          = IW'((int'(i_last) + k) % N);
         o_grant[w_idx] = o_grant[w_idx] | (i_req[w_idx] & ~o_found);
         o_found        = o_found | i_req[w_idx];
      end
   end

endmodule

// File: rtl/pcie_c2h_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing the C2H AXI-Stream channel.
// Data path is a pure mux on the registered owner; a link drop mid-packet
// switches to draining the owner until its tlast, counting the lost packet.
module pcie_c2h_stream_arbiter
   import pcie_stream_pkg::*;
#(
   parameter int REQUESTERS  = DEFAULT_REQUESTERS,
   parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
   parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
   input  logic                             system_clock,
   input  logic                             system_reset_n,
   input  logic                             link_up,
   input  logic [REQUESTERS*DATA_WIDTH-1:0] s_tdata,
   input  logic [REQUESTERS*DATA_WIDTH/8-1:0] s_tkeep,
   input  logic [REQUESTERS-1:0]            s_tlast,
   input  logic [REQUESTERS-1:0]            s_tvalid,
   output logic [REQUESTERS-1:0]            s_tready,
   output logic [DATA_WIDTH-1:0]            m_tdata,
   output logic [DATA_WIDTH/8-1:0]          m_tkeep,
   output logic                             m_tlast,
   output logic                             m_tvalid,
   input  logic                             m_tready,
   output logic [REQUESTERS-1:0]            grant,
   output logic [COUNT_WIDTH-1:0]           dropped_count
);

   localparam int IW = owner_idx_width(REQUESTERS);
   localparam int KW = DATA_WIDTH / 8;

   arb_state_t            r_state;
   arb_state_t            w_next_state;
   logic [IW-1:0]         r_owner;
   logic [IW-1:0]         r_last;
   logic [REQUESTERS-1:0] r_grant;
   logic [COUNT_WIDTH-1:0] r_dropped;
   logic [REQUESTERS-1:0] w_pick_grant;
   logic [IW-1:0]         w_pick_idx;
   logic                  w_found;
   logic                  w_xfer_last;
   logic                  w_drain_done;
   logic [DATA_WIDTH-1:0] w_data_arr [REQUESTERS];
   logic [KW-1:0]         w_keep_arr [REQUESTERS];

   // Convert the picker's one-hot winner into an owner index.
   function automatic logic [IW-1:0] onehot_to_idx(input logic [REQUESTERS-1:0] v);
      logic [IW-1:0] idx;
      idx = '0;
      for (int k = 0; k < REQUESTERS; k++) begin
         idx = idx | (v[k] ? IW'(k) : {IW{1'b0}});
      end
      return idx;
   endfunction

   for (genvar g = 0; g < REQUESTERS; g++) begin : g_slice
      assign w_data_arr[g] = s_tdata[g*DATA_WIDTH +: DATA_WIDTH];
      assign w_keep_arr[g] = s_tkeep[g*KW +: KW];
   end

   round_robin_picker #(
      .N  (REQUESTERS),
      .IW (IW)
   ) u_picker (
      .i_req   (s_tvalid),
      .i_last  (r_last),
      .o_grant (w_pick_grant),
      .o_found (w_found)
   );

   assign w_pick_idx    = onehot_to_idx(w_pick_grant);
   assign grant         = r_grant;
   assign dropped_count = r_dropped;

   // Stream mux: owner's slice passes straight through; nothing flows with no owner.
   always_comb begin
      m_tdata  = '0;
      m_tkeep  = '0;
      m_tlast  = 1'b0;
      m_tvalid = 1'b0;
      s_tready = '0;
      case (r_state)
         PASS: begin
            m_tdata           = w_data_arr[r_owner];
            m_tkeep           = w_keep_arr[r_owner];
            m_tlast           = s_tlast[r_owner];
            m_tvalid          = s_tvalid[r_owner];
            s_tready[r_owner] = m_tready;
         end
         DRAIN: begin
            // DMA side is down: swallow owner beats without presenting them.
            m_tdata           = w_data_arr[r_owner];
            m_tkeep           = w_keep_arr[r_owner];
            m_tlast           = s_tlast[r_owner];
            s_tready[r_owner] = 1'b1;
         end
         default: begin
            m_tdata = '0;
         end
      endcase
   end

   // Next-state decision; a completing tlast beat wins over a simultaneous link drop.
   always_comb begin
      w_next_state = r_state;
      w_xfer_last  = m_tvalid & m_tready & m_tlast;
      w_drain_done = s_tvalid[r_owner] & s_tlast[r_owner];
      case (r_state)
         IDLE: begin
            if (link_up && w_found) begin
               w_next_state = PASS;
            end else begin
               w_next_state = IDLE;
            end
         end
         PASS: begin
            if (w_xfer_last) begin
               w_next_state = IDLE;
            end else if (!link_up) begin
               w_next_state = DRAIN;
            end else begin
               w_next_state = PASS;
            end
         end
         DRAIN: begin
            if (w_drain_done) begin
               w_next_state = IDLE;
            end else begin
               w_next_state = DRAIN;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // State, owner, round-robin pointer and grant registers.
   always_ff @(posedge system_clock or negedge system_reset_n) begin
      if (!system_reset_n) begin
         r_state <= IDLE;
         r_owner <= '0;
         r_last  <= IW'(REQUESTERS - 1);
         r_grant <= '0;
      end else begin
         r_state <= w_next_state;
         if (r_state == IDLE && w_next_state == PASS) begin
            r_owner <= w_pick_idx;
            r_last  <= w_pick_idx;
            r_grant <= w_pick_grant;
         end else if (w_next_state == IDLE) begin
            r_grant <= '0;
         end else begin
            r_grant <= r_grant;
         end
      end
   end

   // Saturating count of packets that had to be drained after link loss.
   always_ff @(posedge system_clock or negedge system_reset_n) begin
      if (!system_reset_n) begin
         r_dropped <= '0;
      end else if (r_state == DRAIN && w_drain_done && r_dropped != {COUNT_WIDTH{1'b1}}) begin
         r_dropped <= r_dropped + COUNT_WIDTH'(1);
      end else begin
         r_dropped <= r_dropped;
      end
   end

endmodule
